gpio_apb_arbiter: RTL and testbench

Two-port APB master arbiter that shares a single CoreGPIO APB slave between two register-access requesters (e.g. firmware bridge and hardware sequencer). Each requester issues single read/write transfers over a simple req/ack interface. The block round-robin arbitrates, runs the APB SETUP/ACCESS protocol including PREADY wait states, and returns read data and error status. It sits between the requesters and the CoreGPIO APB slave port, on the GPIO clock domain.

---
 rtl/gpio_apb_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_gpio_apb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter: round-robin arbiter that lets two requesters share one
// CoreGPIO APB slave. Each requester issues single read/write transfers over
// a req/ack handshake; the block runs SETUP/ACCESS with PREADY wait states,
// aborts after TIMEOUT ACCESS cycles and returns read data plus error status.
module gpio_apb_arbiter #(
  parameter int APB_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic                 WR0,
  input  logic                 WR1,
  input  logic [7:0]           ADDR0,
  input  logic [7:0]           ADDR1,
  input  logic [APB_WIDTH-1:0] WDATA0,
  input  logic [APB_WIDTH-1:0] WDATA1,
  output logic                 ACK0,
  output logic                 ACK1,
  output logic [APB_WIDTH-1:0] RDATA0,
  output logic [APB_WIDTH-1:0] RDATA1,
  output logic                 ERR0,
  output logic                 ERR1,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [7:0]           PADDR,
  output logic [APB_WIDTH-1:0] PWDATA,
  input  logic [APB_WIDTH-1:0] PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // Last ACCESS cycle index before the transfer is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]           state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic                 last_q, last_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [7:0]           paddr_q, paddr_d;
  logic [APB_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic [APB_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [APB_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                 err0_q, err0_d;
  logic                 err1_q, err1_d;

  // Completion result shared by the PREADY and timeout paths.
  logic                 fin;
  logic                 fin_err;
  logic [APB_WIDTH-1:0] fin_rdata;
  logic                 win1;

  // Next-state, arbitration and completion logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err0_d    = err0_q;
    err1_d    = err1_q;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    // Port 1 wins when alone, or when both request and port 0 went last.
    win1      = REQ1 & (~REQ0 | ~last_q);

    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          gnt_d    = win1;
          pwrite_d = win1 ? WR1 : WR0;
          paddr_d  = win1 ? ADDR1 : ADDR0;
          pwdata_d = win1 ? WDATA1 : WDATA0;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          fin       = 1'b1;
          fin_err   = PSLVERR;
          fin_rdata = PRDATA;
        end else if (cnt_q == CNT_LAST) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          fin_rdata = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (fin) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = RESP;
          if (gnt_q) begin
            ack1_d = 1'b1;
            err1_d = fin_err;
            if (!pwrite_q) rdata1_d = fin_rdata;
          end else begin
            ack0_d = 1'b1;
            err0_d = fin_err;
            if (!pwrite_q) rdata0_d = fin_rdata;
          end
        end
      end
      default: begin
        last_d  = gnt_q;
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight transfer.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= 8'd0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 8'd0;
      pwdata_q  <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign ACK0    = ack0_q;
  assign ACK1    = ack1_q;
  assign RDATA0  = rdata0_q;
  assign RDATA1  = rdata1_q;
  assign ERR0    = err0_q;
  assign ERR1    = err1_q;

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Scoreboard bench for gpio_apb_arbiter with a small CoreGPIO-like APB slave.
module tb_gpio_apb_arbiter;
  localparam int W  = 32;
  localparam int TO = 16;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic         REQ0, REQ1, WR0, WR1;
  logic [7:0]   ADDR0, ADDR1;
  logic [W-1:0] WDATA0, WDATA1;
  logic         ACK0, ACK1;
  logic [W-1:0] RDATA0, RDATA1;
  logic         ERR0, ERR1;
  logic         PSEL, PENABLE, PWRITE;
  logic [7:0]   PADDR;
  logic [W-1:0] PWDATA;
  logic [W-1:0] PRDATA;
  logic         PREADY, PSLVERR;

  gpio_apb_arbiter #(.APB_WIDTH(W), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .ERR0(ERR0), .ERR1(ERR1),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: GPIO_IN readable at 0x90, GPIO_OUT writable at 0xA0.
  int           wait_n  = 0;
  bit           hang    = 1'b0;
  bit           slv_err = 1'b0;
  int           acc_cnt = 0;
  logic [W-1:0] gpio_in = 32'h0000_003C;
  logic [W-1:0] gpio_out;

  assign PREADY  = PSEL && PENABLE && !hang && (acc_cnt >= wait_n);
  assign PSLVERR = slv_err && PREADY;
  assign PRDATA  = (PADDR == 8'h90) ? gpio_in : '0;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && PADDR == 8'hA0) gpio_out <= PWDATA;
  end

  // Scoreboard.
  typedef struct packed {
    logic         port;
    logic [W-1:0] rdata;
    logic         err;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  logic [W-1:0] model_rd [2];

  task automatic push(input logic p, input logic wr, input logic [W-1:0] rd, input logic er);
    exp_t e;
    e.port = p;
    e.err  = er;
    if (wr) e.rdata = model_rd[p];
    else begin
      model_rd[p] = rd;
      e.rdata     = rd;
    end
    sbq.push_back(e);
  endtask

  always @(negedge PCLK) begin
    if (!PRESET && (ACK0 || ACK1)) begin
      check("ack_overlap", 64'(ACK0 & ACK1), 64'd0);
      if (sbq.size() == 0) check("unexpected_ack", 64'({ACK1, ACK0}), 64'd0);
      else begin
        mon_e = sbq.pop_front();
        check("ack_port", 64'(ACK1), 64'(mon_e.port));
        check("rdata", 64'(mon_e.port ? RDATA1 : RDATA0), 64'(mon_e.rdata));
        check("err", 64'(mon_e.port ? ERR1 : ERR0), 64'(mon_e.err));
      end
    end
  end

  // Per-cycle trace of the most recent transfer (index = cycle number).
  logic         tr_psel [32];
  logic         tr_pen  [32];
  logic [W-1:0] tr_pwd  [32];

  task automatic xfer(input logic p, input logic wr, input logic [7:0] a,
                      input logic [W-1:0] wd, output int lat);
    @(posedge PCLK); #1;
    if (p) begin REQ1 = 1'b1; WR1 = wr; ADDR1 = a; WDATA1 = wd; end
    else begin REQ0 = 1'b1; WR0 = wr; ADDR0 = a; WDATA0 = wd; end
    lat = 0;
    forever begin
      @(posedge PCLK); #1;
      lat++;
      if (lat < 32) begin
        tr_psel[lat] = PSEL;
        tr_pen[lat]  = PENABLE;
        tr_pwd[lat]  = PWDATA;
      end
      if ((p ? ACK1 : ACK0) === 1'b1) break;
      if (lat >= 300) begin
        check(p ? "ack_wait_p1" : "ack_wait_p0", 64'({ACK1, ACK0}), p ? 64'd2 : 64'd1);
        break;
      end
    end
    if (p) REQ1 = 1'b0;
    else REQ0 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, l0, l1;
    PRESET = 1'b1;
    REQ0 = 0; REQ1 = 0; WR0 = 0; WR1 = 0;
    ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0;
    model_rd[0] = '0;
    model_rd[1] = '0;
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_psel", 64'(PSEL), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_pwrite", 64'(PWRITE), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    check("rst_pwdata", 64'(PWDATA), 64'd0);
    check("rst_ack", 64'({ACK1, ACK0}), 64'd0);
    check("rst_rdata0", 64'(RDATA0), 64'd0);
    check("rst_rdata1", 64'(RDATA1), 64'd0);
    check("rst_err", 64'({ERR1, ERR0}), 64'd0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // Port 0 write to GPIO_OUT.
    push(1'b0, 1'b1, '0, 1'b0);
    xfer(1'b0, 1'b1, 8'hA0, 32'h0000_00A5, lat);
    check("wr_latency", 64'(lat), 64'd3);
    check("wr_psel_c1", 64'(tr_psel[1]), 64'd1);
    check("wr_pen_c1", 64'(tr_pen[1]), 64'd0);
    check("wr_pen_c2", 64'(tr_pen[2]), 64'd1);
    check("wr_pwdata_c2", 64'(tr_pwd[2]), 64'h0000_00A5);
    check("gpio_out", 64'(gpio_out), 64'h0000_00A5);

    // Port 1 read of GPIO_IN.
    push(1'b1, 1'b0, 32'h0000_003C, 1'b0);
    xfer(1'b1, 1'b0, 8'h90, '0, lat);
    check("rd_latency", 64'(lat), 64'd3);
    check("rd_rdata1", 64'(RDATA1), 64'h3C);
    check("rd_rdata0_kept", 64'(RDATA0), 64'(model_rd[0]));

    // Simultaneous pair after port 1 went last: port 0 first.
    push(1'b0, 1'b1, '0, 1'b0);
    push(1'b1, 1'b0, 32'h0000_003C, 1'b0);
    fork
      xfer(1'b0, 1'b1, 8'hA0, 32'h11, l0);
      xfer(1'b1, 1'b0, 8'h90, '0, l1);
    join
    check("pair1_lat0", 64'(l0), 64'd3);
    check("pair1_lat1", 64'(l1), 64'd7);

    // A single port-0 transfer, then a pair: port 1 first.
    push(1'b0, 1'b1, '0, 1'b0);
    xfer(1'b0, 1'b1, 8'hA0, 32'h22, lat);
    push(1'b1, 1'b0, 32'h0000_003C, 1'b0);
    push(1'b0, 1'b1, '0, 1'b0);
    fork
      xfer(1'b0, 1'b1, 8'hA0, 32'h33, l0);
      xfer(1'b1, 1'b0, 8'h90, '0, l1);
    join
    check("pair2_lat1", 64'(l1), 64'd3);
    check("pair2_lat0", 64'(l0), 64'd7);
    check("gpio_out_pair2", 64'(gpio_out), 64'h33);

    // Three wait states then PSLVERR.
    wait_n = 3;
    slv_err = 1'b1;
    push(1'b0, 1'b0, 32'h0000_003C, 1'b1);
    xfer(1'b0, 1'b0, 8'h90, '0, lat);
    check("wait_latency", 64'(lat), 64'd6);
    check("wait_pen_c1", 64'(tr_pen[1]), 64'd0);
    for (int c = 2; c <= 5; c++) check($sformatf("wait_pen_c%0d", c), 64'(tr_pen[c]), 64'd1);
    wait_n = 0;
    slv_err = 1'b0;

    // PREADY held low: timeout.
    hang = 1'b1;
    push(1'b1, 1'b0, '0, 1'b1);
    xfer(1'b1, 1'b0, 8'h90, '0, lat);
    check("to_latency", 64'(lat), 64'd18);
    check("to_pen_c17", 64'(tr_pen[17]), 64'd1);
    hang = 1'b0;
    push(1'b1, 1'b0, 32'h0000_003C, 1'b0);
    xfer(1'b1, 1'b0, 8'h90, '0, lat);
    check("after_to_latency", 64'(lat), 64'd3);

    // Reset during ACCESS.
    @(posedge PCLK); #1;
    REQ0 = 1'b1; WR0 = 1'b0; ADDR0 = 8'h90;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check("pre_rst_penable", 64'(PENABLE), 64'd1);
    #2 PRESET = 1'b1;
    #1;
    check("mid_rst_psel", 64'(PSEL), 64'd0);
    check("mid_rst_penable", 64'(PENABLE), 64'd0);
    check("mid_rst_ack", 64'({ACK1, ACK0}), 64'd0);
    check("mid_rst_rdata1", 64'(RDATA1), 64'd0);
    REQ0 = 1'b0;
    model_rd[0] = '0;
    model_rd[1] = '0;
    @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (5) @(posedge PCLK);
    push(1'b0, 1'b0, 32'h0000_003C, 1'b0);
    xfer(1'b0, 1'b0, 8'h90, '0, lat);
    check("post_rst_latency", 64'(lat), 64'd3);

    repeat (3) @(posedge PCLK);
    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
